// File: rtl/mem_lsu_stage_if.sv
// Data-bus interface between the MEM stage (master) and the memory port (slave).
// Request/accept/response handshake: req+addr_ok accepts a request, rvalid returns load data.
interface mem_lsu_stage_if #(
    parameter int DATA_W = 32
);
    logic              dbus_req;
    logic              dbus_we;
    logic [DATA_W-1:0] dbus_addr;
    logic [3:0]        dbus_wstrb;
    logic [DATA_W-1:0] dbus_wdata;
    logic              dbus_addr_ok;
    logic              dbus_rvalid;
    logic [DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_addr_ok, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_addr_ok, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus, formats load data,
// stalls the pipe while a transaction is outstanding and drives the MEM/WB triple.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | decode EX/MEM fields; ALU ops pass through; aligned mem ops issue
// REQ    | request not yet accepted; latched fields held on the bus
// WAIT   | load accepted; waiting for rvalid
// DONE   | one-cycle write-back of the finished op; pause released
module mem_lsu_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     mem_reg_write_data,
    input  logic [REG_ADDR_W-1:0] mem_reg_write_addr,
    input  logic                  mem_reg_write_en,
    input  logic [3:0]            mem_op,
    input  logic [DATA_W-1:0]     mem_store_data,
    mem_lsu_stage_if.master       dbus,
    output logic [DATA_W-1:0]     wb_reg_write_data,
    output logic [REG_ADDR_W-1:0] wb_reg_write_addr,
    output logic                  wb_reg_write_en,
    output logic                  pause_request,
    output logic                  excp_ale
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t            r_state;
    logic [DATA_W-1:0] r_req_addr;
    logic              r_req_we;
    logic [3:0]        r_req_wstrb;
    logic [DATA_W-1:0] r_req_wdata;
    logic [DATA_W-1:0] r_load_buf;
    logic [3:0]        r_op;
    logic [1:0]        r_addr_lo;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_misalign;
    logic              w_go;
    logic [DATA_W-1:0] w_addr_in;
    logic [3:0]        w_wstrb_in;
    logic [DATA_W-1:0] w_wdata_in;
    logic [DATA_W-1:0] w_load_fmt;

    // Little-endian lane select with sign/zero extension of the buffered load word.
    function automatic logic [DATA_W-1:0] f_format(input logic [3:0] op,
                                                   input logic [1:0] lo,
                                                   input logic [DATA_W-1:0] word);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        case (lo)
            2'd0:    v_b = word[7:0];
            2'd1:    v_b = word[15:8];
            2'd2:    v_b = word[23:16];
            default: v_b = word[31:24];
        endcase
        v_h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   f_format = {{24{v_b[7]}}, v_b};
            OP_LBU:  f_format = {24'd0, v_b};
            OP_LH:   f_format = {{16{v_h[15]}}, v_h};
            OP_LHU:  f_format = {16'd0, v_h};
            default: f_format = word;
        endcase
    endfunction

    // Decode the incoming memory op: class, alignment and bus encoding.
    always_comb begin
        w_is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
        w_is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        w_misalign = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH))
                      && mem_reg_write_data[0])
                   || (((mem_op == OP_LW) || (mem_op == OP_SW))
                      && (mem_reg_write_data[1:0] != 2'b00));
        w_go       = (r_state == S_IDLE) && (w_is_load || w_is_store) && !w_misalign;
        w_addr_in  = {mem_reg_write_data[31:2], 2'b00};
        case (mem_op)
            OP_SB:   w_wstrb_in = 4'b0001 << mem_reg_write_data[1:0];
            OP_SH:   w_wstrb_in = 4'b0011 << mem_reg_write_data[1:0];
            OP_SW:   w_wstrb_in = 4'b1111;
            default: w_wstrb_in = 4'b0000;
        endcase
        case (mem_op)
            OP_SB:   w_wdata_in = {4{mem_store_data[7:0]}};
            OP_SH:   w_wdata_in = {2{mem_store_data[15:0]}};
            OP_SW:   w_wdata_in = mem_store_data;
            default: w_wdata_in = '0;
        endcase
        w_load_fmt = f_format(r_op, r_addr_lo, r_load_buf);
    end

    // Bus, pause and write-back outputs; all forced low while reset is held.
    always_comb begin
        dbus.dbus_req     = 1'b0;
        dbus.dbus_we      = 1'b0;
        dbus.dbus_addr    = '0;
        dbus.dbus_wstrb   = 4'b0000;
        dbus.dbus_wdata   = '0;
        wb_reg_write_data = '0;
        wb_reg_write_addr = '0;
        wb_reg_write_en   = 1'b0;
        pause_request     = 1'b0;
        excp_ale          = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    wb_reg_write_data = mem_reg_write_data;
                    wb_reg_write_addr = mem_reg_write_addr;
                    wb_reg_write_en   = mem_reg_write_en && !w_is_load && !w_is_store;
                    excp_ale          = (w_is_load || w_is_store) && w_misalign;
                    if (w_go) begin
                        dbus.dbus_req   = 1'b1;
                        dbus.dbus_we    = w_is_store;
                        dbus.dbus_addr  = w_addr_in;
                        dbus.dbus_wstrb = w_wstrb_in;
                        dbus.dbus_wdata = w_wdata_in;
                        pause_request   = !(w_is_store && dbus.dbus_addr_ok);
                    end
                end
                S_REQ: begin
                    dbus.dbus_req   = 1'b1;
                    dbus.dbus_we    = r_req_we;
                    dbus.dbus_addr  = r_req_addr;
                    dbus.dbus_wstrb = r_req_wstrb;
                    dbus.dbus_wdata = r_req_wdata;
                    pause_request   = 1'b1;
                end
                S_WAIT: begin
                    pause_request = 1'b1;
                end
                S_DONE: begin
                    wb_reg_write_data = w_load_fmt;
                    wb_reg_write_addr = mem_reg_write_addr;
                    wb_reg_write_en   = mem_reg_write_en && !r_req_we;
                end
                default: ;
            endcase
        end
    end

    // Transaction FSM and request/response latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wstrb <= 4'b0000;
            r_req_wdata <= '0;
            r_load_buf  <= '0;
            r_op        <= 4'd0;
            r_addr_lo   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_req_addr  <= w_addr_in;
                        r_req_we    <= w_is_store;
                        r_req_wstrb <= w_wstrb_in;
                        r_req_wdata <= w_wdata_in;
                        r_op        <= mem_op;
                        r_addr_lo   <= mem_reg_write_data[1:0];
                        if (!dbus.dbus_addr_ok)
                            r_state <= S_REQ;
                        else if (w_is_load)
                            r_state <= S_WAIT;
                    end
                end
                S_REQ: begin
                    if (dbus.dbus_addr_ok)
                        r_state <= r_req_we ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (dbus.dbus_rvalid) begin
                        r_load_buf <= dbus.dbus_rdata;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage with a scoreboard: stimulus queues expected
// bus requests and write-backs, monitors pop and compare when the DUT presents them.
module tb_mem_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_reg_write_data;
    logic [4:0]  mem_reg_write_addr;
    logic        mem_reg_write_en;
    logic [3:0]  mem_op;
    logic [31:0] mem_store_data;
    logic [31:0] wb_reg_write_data;
    logic [4:0]  wb_reg_write_addr;
    logic        wb_reg_write_en;
    logic        pause_request;
    logic        excp_ale;

    mem_lsu_stage_if #(.DATA_W(32)) u_if ();

    mem_lsu_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_reg_write_data (mem_reg_write_data),
        .mem_reg_write_addr (mem_reg_write_addr),
        .mem_reg_write_en   (mem_reg_write_en),
        .mem_op             (mem_op),
        .mem_store_data     (mem_store_data),
        .dbus               (u_if.master),
        .wb_reg_write_data  (wb_reg_write_data),
        .wb_reg_write_addr  (wb_reg_write_addr),
        .wb_reg_write_en    (wb_reg_write_en),
        .pause_request      (pause_request),
        .excp_ale           (excp_ale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd3, LHU = 4'd4,
                           LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Bus monitor: every accepted request must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && u_if.dbus_req && u_if.dbus_addr_ok) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_req", 32'd1, 32'd0);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("bus_we",    {31'd0, u_if.dbus_we}, {31'd0, e.we});
                chk("bus_addr",  u_if.dbus_addr, e.addr);
                chk("bus_wstrb", {28'd0, u_if.dbus_wstrb}, {28'd0, e.wstrb});
                chk("bus_wdata", u_if.dbus_wdata, e.wdata);
            end
        end
    end

    // Write-back monitor: every enabled write-back must match the next expectation.
    always @(negedge clk) begin
        if (!rst && wb_reg_write_en) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                chk("wb_addr", {27'd0, wb_reg_write_addr}, {27'd0, e.addr});
                chk("wb_data", wb_reg_write_data, e.data);
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [4:0] rd,
                         input logic en, input logic [31:0] sd);
        mem_op             = op;
        mem_reg_write_data = a;
        mem_reg_write_addr = rd;
        mem_reg_write_en   = en;
        mem_store_data     = sd;
    endtask

    // Load accepted immediately, data returned the next cycle, then one DONE cycle.
    task automatic do_load(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdat,
                           input logic [31:0] exp);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        step();
        drive(op, a, rd, 1'b1, 32'h0);
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b0, wa, 4'b0000, 32'h0});
        smp();
        chk({nm, "_pause_issue"}, {31'd0, pause_request}, 32'd1);
        step();
        u_if.dbus_addr_ok = 1'b0;
        u_if.dbus_rvalid  = 1'b1;
        u_if.dbus_rdata   = rdat;
        wb_q.push_back('{rd, exp});
        smp();
        chk({nm, "_pause_wait"}, {31'd0, pause_request}, 32'd1);
        step();
        u_if.dbus_rvalid = 1'b0;
        smp();
        chk({nm, "_pause_done"}, {31'd0, pause_request}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
        u_if.dbus_addr_ok = 1'b0;
        u_if.dbus_rvalid  = 1'b0;
        u_if.dbus_rdata   = 32'h0;
        smp();
        chk("reset_outputs", {26'd0, u_if.dbus_req, pause_request, excp_ale,
                              wb_reg_write_en, u_if.dbus_we, 1'b0}, 32'd0);
        step();
        rst = 1'b0;

        // ALU passthrough
        step();
        drive(NONE, 32'h1234_5678, 5'd3, 1'b1, 32'h0);
        wb_q.push_back('{5'd3, 32'h1234_5678});
        smp();
        chk("alu_pause", {31'd0, pause_request}, 32'd0);
        chk("alu_req", {31'd0, u_if.dbus_req}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);

        // LB at 0x1003, accepted cycle 0, rvalid cycle 2
        step();
        drive(LB, 32'h0000_1003, 5'd7, 1'b1, 32'h0);
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b0, 32'h0000_1000, 4'b0000, 32'h0});
        smp();
        chk("lb_pause_c0", {31'd0, pause_request}, 32'd1);
        chk("lb_wben_c0", {31'd0, wb_reg_write_en}, 32'd0);
        step();
        u_if.dbus_addr_ok = 1'b0;
        smp();
        chk("lb_pause_c1", {31'd0, pause_request}, 32'd1);
        chk("lb_req_wait", {31'd0, u_if.dbus_req}, 32'd0);
        step();
        u_if.dbus_rvalid = 1'b1;
        u_if.dbus_rdata  = 32'h80FF_0000;
        smp();
        chk("lb_pause_c2", {31'd0, pause_request}, 32'd1);
        step();
        u_if.dbus_rvalid = 1'b0;
        u_if.dbus_rdata  = 32'h0;
        wb_q.push_back('{5'd7, 32'hFFFF_FF80});
        smp();
        chk("lb_pause_done", {31'd0, pause_request}, 32'd0);
        chk("lb_no_reissue", {31'd0, u_if.dbus_req}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);

        // SH at 0x2002, accept delayed 3 cycles; source data disturbed while stalled
        step();
        drive(SH, 32'h0000_2002, 5'd0, 1'b0, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                step();
                mem_store_data = 32'hFFFF_0000;
            end
            smp();
            chk("sh_req",   {31'd0, u_if.dbus_req}, 32'd1);
            chk("sh_addr",  u_if.dbus_addr, 32'h0000_2000);
            chk("sh_wstrb", {28'd0, u_if.dbus_wstrb}, 32'hC);
            chk("sh_wdata", u_if.dbus_wdata, 32'hABCD_ABCD);
            chk("sh_pause", {31'd0, pause_request}, 32'd1);
        end
        step();
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD});
        smp();
        chk("sh_pause_accept", {31'd0, pause_request}, 32'd1);
        step();
        u_if.dbus_addr_ok = 1'b0;
        smp();
        chk("sh_pause_done", {31'd0, pause_request}, 32'd0);
        chk("sh_wben_done", {31'd0, wb_reg_write_en}, 32'd0);
        chk("sh_req_done", {31'd0, u_if.dbus_req}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);

        // Misaligned LW
        step();
        drive(LW, 32'h0000_3001, 5'd2, 1'b1, 32'h0);
        smp();
        chk("lw_mis_ale", {31'd0, excp_ale}, 32'd1);
        chk("lw_mis_req", {31'd0, u_if.dbus_req}, 32'd0);
        chk("lw_mis_wben", {31'd0, wb_reg_write_en}, 32'd0);
        chk("lw_mis_pause", {31'd0, pause_request}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
        smp();
        chk("ale_clear", {31'd0, excp_ale}, 32'd0);

        // LHU upper half, then back-to-back SW accepted same cycle
        do_load("lhu", LHU, 32'h0000_4002, 5'd9, 32'h8001_0000, 32'h0000_8001);
        drive(SW, 32'h0000_5000, 5'd0, 1'b0, 32'hDEAD_BEEF);
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b1, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF});
        smp();
        chk("sw_pause", {31'd0, pause_request}, 32'd0);
        chk("sw_wben", {31'd0, wb_reg_write_en}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
        u_if.dbus_addr_ok = 1'b0;
        smp();
        chk("sw_single_req", {31'd0, u_if.dbus_req}, 32'd0);
        chk("sw_idle_pause", {31'd0, pause_request}, 32'd0);

        // LH sign-extension on upper lane, SB lane replication
        do_load("lh", LH, 32'h0000_6002, 5'd10, 32'h8001_1234, 32'hFFFF_8001);
        drive(SB, 32'h0000_7001, 5'd0, 1'b0, 32'h0000_005A);
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b1, 32'h0000_7000, 4'b0010, 32'h5A5A_5A5A});
        smp();
        chk("sb_pause", {31'd0, pause_request}, 32'd0);
        step();
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
        u_if.dbus_addr_ok = 1'b0;

        // Reset during WAIT, stray rvalid afterwards, then a clean LW
        step();
        drive(LW, 32'h0000_8000, 5'd4, 1'b1, 32'h0);
        u_if.dbus_addr_ok = 1'b1;
        bus_q.push_back('{1'b0, 32'h0000_8000, 4'b0000, 32'h0});
        smp();
        step();
        u_if.dbus_addr_ok = 1'b0;
        smp();
        chk("rst_pre_pause", {31'd0, pause_request}, 32'd1);
        step();
        rst = 1'b1;
        smp();
        chk("rst_mid_ctl", {26'd0, u_if.dbus_req, pause_request, excp_ale,
                            wb_reg_write_en, u_if.dbus_we, 1'b0}, 32'd0);
        chk("rst_mid_wbdata", wb_reg_write_data, 32'd0);
        chk("rst_mid_wbaddr", {27'd0, wb_reg_write_addr}, 32'd0);
        step();
        rst = 1'b0;
        drive(NONE, 32'h0, 5'd0, 1'b0, 32'h0);
        smp();
        chk("rst_after_pause", {31'd0, pause_request}, 32'd0);
        step();
        u_if.dbus_rvalid = 1'b1;
        u_if.dbus_rdata  = 32'hDEAD_DEAD;
        smp();
        chk("stray_pause", {31'd0, pause_request}, 32'd0);
        chk("stray_wben", {31'd0, wb_reg_write_en}, 32'd0);
        step();
        u_if.dbus_rvalid = 1'b0;
        smp();
        chk("stray_wben_next", {31'd0, wb_reg_write_en}, 32'd0);
        do_load("lw_post_rst", LW, 32'h0000_8004, 5'd5, 32'h1122_3344, 32'h1122_3344);

        step();
        step();
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
